// File: rtl/btn_write_strobe_if.sv
// rtl/btn_write_strobe_if.sv - write-strobe bus between the button front end and the byte store
// Ports (modports):
//   master : drives wr_en (1-cycle strobe), wr_addr (entry select), wr_data (byte)
//   slave  : receives the same three signals
interface btn_write_strobe_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/btn_write_strobe.sv
// rtl/btn_write_strobe.sv - debounced push-button to single-cycle write strobe with switch capture
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn_raw      : raw bouncy push-button level
//   sw_data      : raw data switches
//   sw_sel       : raw entry-select switches
//   wr           : write bus (wr_en / wr_addr / wr_data), master side
//   btn_level    : debounced button level
//   press_count  : accepted presses, wraps at 8 bits
module btn_write_strobe #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_raw,
    input  logic [DATA_W-1:0]   sw_data,
    input  logic [ADDR_W-1:0]   sw_sel,
    btn_write_strobe_if.master  wr,
    output logic                btn_level,
    output logic [7:0]          press_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic              btn_m,  btn_s;
    logic [DATA_W-1:0] data_m, data_s;
    logic [ADDR_W-1:0] sel_m,  sel_s;

    // Two-flop synchronizers; the switches are only meaningful when the
    // strobe fires, by which time they have settled through both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_m  <= 1'b0;
            btn_s  <= 1'b0;
            data_m <= '0;
            data_s <= '0;
            sel_m  <= '0;
            sel_s  <= '0;
        end else begin
            btn_m  <= btn_raw;
            btn_s  <= btn_m;
            data_m <= sw_data;
            data_s <= data_m;
            sel_m  <= sw_sel;
            sel_s  <= sel_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            wr.wr_en    <= 1'b0;
            wr.wr_addr  <= '0;
            wr.wr_data  <= '0;
            btn_level   <= 1'b0;
            press_count <= 8'd0;
        end else begin
            wr.wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Only place a strobe is generated: one per debounced press.
                        state       <= PRESSED;
                        cnt         <= '0;
                        wr.wr_en    <= 1'b1;
                        wr.wr_addr  <= sel_s;
                        wr.wr_data  <= data_s;
                        press_count <= press_count + 8'd1;
                        btn_level   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A return to high here is release bounce: back to PRESSED
                    // without a strobe, since the press was already accepted.
                    if (btn_s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_write_strobe.sv
// tb/tb_btn_write_strobe.sv - self-checking bench for btn_write_strobe with strobe scoreboard
module tb_btn_write_strobe;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_raw;
    logic [7:0] sw_data;
    logic [1:0] sw_sel;
    logic       btn_level;
    logic [7:0] press_count;

    btn_write_strobe_if #(.DATA_W(8), .ADDR_W(2)) wr_bus ();

    btn_write_strobe #(.DEBOUNCE_CYCLES(DB), .DATA_W(8), .ADDR_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .sw_data     (sw_data),
        .sw_sel      (sw_sel),
        .wr          (wr_bus),
        .btn_level   (btn_level),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         edge_no;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] count;
    } strobe_t;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        int         bounce;
        int         hold;
    } vec_t;

    strobe_t    sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_count = 8'd0;
    vec_t       vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every strobe the DUT produces must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                strobe_t e;
                e = sb.pop_front();
                chk("strobe_edge",  32'(cyc),           32'(e.edge_no));
                chk("strobe_addr",  32'(wr_bus.wr_addr), 32'(e.addr));
                chk("strobe_data",  32'(wr_bus.wr_data), 32'(e.data));
                chk("strobe_count", 32'(press_count),    32'(e.count));
            end
        end
    end

    task automatic go_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_strobe(input int at, input logic [1:0] a, input logic [7:0] d);
        strobe_t e;
        exp_count = exp_count + 8'd1;
        e.edge_no = at;
        e.addr    = a;
        e.data    = d;
        e.count   = exp_count;
        sb.push_back(e);
    endtask

    task automatic release_btn();
        int r;
        r = cyc;
        btn_raw = 1'b0;
        go_to(r + DB + 2);
        chk("level_before_release", 32'(btn_level), 32'd1);
        go_to(r + DB + 3);
        chk("level_after_release", 32'(btn_level), 32'd0);
        go_to(r + DB + 6);
    endtask

    // Optional single-cycle glitches, then a final rise held for `hold` cycles.
    task automatic press(input logic [1:0] s, input logic [7:0] d, input int bounce,
                         input int hold, input bit do_release);
        int f;
        sw_sel  = s;
        sw_data = d;
        for (int i = 0; i < bounce; i++) begin
            btn_raw = 1'b1;
            @(negedge clk);
            btn_raw = 1'b0;
            @(negedge clk);
        end
        f = cyc;
        btn_raw = 1'b1;
        expect_strobe(f + DB + 3, s, d);
        go_to(f + DB + 2);
        chk("level_low_pre_strobe", 32'(btn_level), 32'd0);
        go_to(f + DB + 3);
        chk("level_high_at_strobe", 32'(btn_level), 32'd1);
        go_to(f + hold);
        if (do_release) release_btn();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wr_en"},   32'(wr_bus.wr_en),   32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_bus.wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_bus.wr_data), 32'd0);
        chk({tag, "_level"},   32'(btn_level),      32'd0);
        chk({tag, "_count"},   32'(press_count),    32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{sel: 2'd2, data: 8'hA5, bounce: 0, hold: 20};
        vecs[1] = '{sel: 2'd1, data: 8'h5A, bounce: 2, hold: 10};
        vecs[2] = '{sel: 2'd0, data: 8'h00, bounce: 0, hold: 9};
        vecs[3] = '{sel: 2'd3, data: 8'hFF, bounce: 1, hold: 12};
        vecs[4] = '{sel: 2'd2, data: 8'h81, bounce: 3, hold: 40};
        vecs[5] = '{sel: 2'd0, data: 8'h7E, bounce: 0, hold: 9};

        // Reset held with button pressed and switches toggling.
        rst_n   = 1'b0;
        btn_raw = 1'b1;
        sw_sel  = 2'd0;
        sw_data = 8'h00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sw_sel  = 2'(i + 1);
            sw_data = 8'(8'h11 * (i + 3));
            #1 chk_outputs_zero("in_reset");
        end
        @(negedge clk);
        sw_sel  = 2'd1;
        sw_data = 8'h42;
        rst_n   = 1'b1;
        n = cyc;
        expect_strobe(n + DB + 3, 2'd1, 8'h42);
        go_to(n + DB + 2);
        chk("reset_rel_no_early_strobe", 32'(press_count), 32'd0);
        go_to(n + 15);
        release_btn();

        // Table of clean and bouncy presses.
        foreach (vecs[i]) press(vecs[i].sel, vecs[i].data, vecs[i].bounce, vecs[i].hold, 1'b1);
        chk("outputs_hold_addr", 32'(wr_bus.wr_addr), 32'd0);
        chk("outputs_hold_data", 32'(wr_bus.wr_data), 32'h7E);

        // Release bounce: low 2, high 1, then low for good.
        press(2'd3, 8'hC3, 0, 10, 1'b0);
        n = cyc;
        btn_raw = 1'b0;
        go_to(n + 2);
        btn_raw = 1'b1;
        go_to(n + 3);
        btn_raw = 1'b0;
        go_to(n + 9);
        chk("relbounce_level_held", 32'(btn_level), 32'd1);
        go_to(n + 10);
        chk("relbounce_level_drop", 32'(btn_level), 32'd0);
        go_to(n + 14);

        // Switch changes while held and after release do not disturb the capture.
        press(2'd1, 8'h3C, 0, 10, 1'b0);
        sw_sel  = 2'd3;
        sw_data = 8'hFF;
        go_to(cyc + 6);
        chk("swhold_addr_held", 32'(wr_bus.wr_addr), 32'd1);
        chk("swhold_data_held", 32'(wr_bus.wr_data), 32'h3C);
        release_btn();
        go_to(cyc + 5);
        chk("swhold_addr_idle", 32'(wr_bus.wr_addr), 32'd1);
        chk("swhold_data_idle", 32'(wr_bus.wr_data), 32'h3C);
        press(2'd3, 8'hFF, 0, 9, 1'b1);

        // Presses until the counter wraps (at least one full wrap).
        n = 0;
        while (n < 256 || exp_count != 8'd0) begin
            press(2'(n), 8'(n * 7), 0, 8, 1'b1);
            n++;
            if (n > 600) break;
        end
        chk("wrap_count", 32'(press_count), 32'd0);

        // Reset during PRESS_WAIT with button kept held.
        sw_sel  = 2'd2;
        sw_data = 8'h77;
        n = cyc;
        btn_raw = 1'b1;
        go_to(n + 4);
        rst_n = 1'b0;
        #1 chk_outputs_zero("mid_reset");
        go_to(n + 8);
        rst_n = 1'b1;
        exp_count = 8'd0;
        n = cyc;
        expect_strobe(n + DB + 3, 2'd2, 8'h77);
        go_to(n + DB + 3);
        chk("post_reset_level", 32'(btn_level), 32'd1);
        go_to(n + 20);
        release_btn();
        chk("post_reset_count", 32'(press_count), 32'd1);

        go_to(cyc + 5);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
